// File: rtl/hpdl_pkg.sv
// Shared constants, dump FSM state type and character sanitiser for the HPDL display path.
package hpdl_pkg;

  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_SUB      = 8'h2E;
  localparam logic [7:0] HPDL_CHAR_MIN = 8'h20;
  localparam logic [7:0] HPDL_CHAR_MAX = 8'h5F;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    NEXT,
    TAIL,
    DONE
  } dump_state_t;

  // Anything outside the HPDL-1414 glyph range is shown as '.'
  function automatic logic [7:0] hpdl_sanitize(input logic [7:0] b);
    return (b >= HPDL_CHAR_MIN && b <= HPDL_CHAR_MAX) ? b : CHAR_SUB;
  endfunction

endpackage

// File: rtl/hpdl_buffer_dump_uart_tx_frame.sv
// 8N1 frame serialiser: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_frame #(
  parameter int BIT_CYC = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [7:0] data,
  output logic       TxD,
  output logic       frame_busy
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_last;

  assign bit_last = (cnt == CW'(BIT_CYC - 1));
  // Drops during the final stop-bit cycle so the sequencer's gap lines up with the frame end
  assign frame_busy = active && !(bit_last && bit_idx == 4'd9);

  always_ff @(posedge CLK) begin
    if (RST) begin
      TxD     <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (load && !active) begin
      active  <= 1'b1;
      TxD     <= 1'b0;
      shreg   <= {1'b1, data};
      cnt     <= '0;
      bit_idx <= '0;
    end else if (active) begin
      if (bit_last) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          TxD    <= 1'b1;
        end else begin
          TxD     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdl_buffer_dump.sv
// Dumps the HPDL display buffer over a dedicated UART TxD line.
// Optional CR/LF trailer enabled by defining HPDL_DUMP_CRLF_EN.
module hpdl_buffer_dump
  import hpdl_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dump_req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              TxD
);

  localparam int BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;

  dump_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic              load;
  logic [7:0]        load_data;
  logic              frame_busy;
  logic              frame_busy_q;
  logic              frame_fall;
  logic              last_frame;

  assign rd_en      = (state == FETCH);
  assign rd_addr    = idx;
  assign frame_fall = frame_busy_q && !frame_busy;

`ifdef HPDL_DUMP_CRLF_EN
  logic       tail_wait;
  logic [1:0] tail_cnt;
  assign last_frame = (tail_cnt == 2'd2);
`else
  assign last_frame = (idx == ADDR_W'(DEPTH - 1));
`endif

  always_comb begin
    load      = (state == WAIT);
    load_data = hpdl_sanitize(rd_data);
`ifdef HPDL_DUMP_CRLF_EN
    if (state == TAIL && tail_wait) begin
      load      = 1'b1;
      load_data = (tail_cnt == 2'd0) ? CHAR_CR : CHAR_LF;
    end
`endif
  end

  // The final frame ends straight into DONE so done/busy change on the edge after the last stop bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      frame_busy_q <= 1'b0;
`ifdef HPDL_DUMP_CRLF_EN
      tail_wait    <= 1'b0;
      tail_cnt     <= '0;
`endif
    end else begin
      frame_busy_q <= frame_busy;
      done         <= 1'b0;
      case (state)
        IDLE: if (dump_req) begin
          idx   <= '0;
          busy  <= 1'b1;
          state <= FETCH;
`ifdef HPDL_DUMP_CRLF_EN
          tail_cnt <= '0;
`endif
        end
        FETCH: state <= WAIT;
        WAIT:  state <= SEND;
        SEND: if (frame_fall) begin
          if (last_frame) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: if (idx < ADDR_W'(DEPTH - 1)) begin
          idx   <= idx + 1'b1;
          state <= FETCH;
        end else begin
          state <= TAIL;
        end
`ifdef HPDL_DUMP_CRLF_EN
        // One idle cycle then load, matching the FETCH/WAIT spacing of data frames
        TAIL: if (!tail_wait) begin
          tail_wait <= 1'b1;
        end else begin
          tail_wait <= 1'b0;
          tail_cnt  <= tail_cnt + 2'd1;
          state     <= SEND;
        end
`else
        TAIL: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_frame #(.BIT_CYC(BIT_CYC)) u_tx (
    .CLK        (CLK),
    .RST        (RST),
    .load       (load),
    .data       (load_data),
    .TxD        (TxD),
    .frame_busy (frame_busy)
  );

endmodule

// File: tb/tb_hpdl_buffer_dump.sv
// Bench for hpdl_buffer_dump: timeline model of the dump, independent UART decoder, directed tests.
module tb_hpdl_buffer_dump;

  localparam int DEPTH = 16;
  localparam int BIT   = 104;
  localparam int FR    = 10 * BIT;
  localparam int SLOT  = FR + 3;
`ifdef HPDL_DUMP_CRLF_EN
  localparam int NF = DEPTH + 2;
`else
  localparam int NF = DEPTH;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       dump_req = 1'b0;
  logic       rd_en, busy, done, TxD;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  hpdl_buffer_dump #(.CLK_HZ(12000000), .BAUD(115200), .DEPTH(DEPTH), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .dump_req(dump_req), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .TxD(TxD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
    cyc <= cyc + 1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [7:0] san(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h5F) ? b : 8'h2E;
  endfunction

  // Model: a dump accepted at cycle r is a fixed timeline of NF frames spaced SLOT cycles apart
  bit         m_act = 1'b0;
  int         m_r = 0;
  int         m_last = 0;
  logic [7:0] m_b [NF];

  always @(posedge CLK) begin
    if (RST) begin
      m_act <= 1'b0;
    end else if (dump_req && !(m_act && cyc <= m_last + 1)) begin
      m_act  <= 1'b1;
      m_r    <= cyc;
      m_last <= cyc + 3 + (NF - 1) * SLOT + FR - 1;
      for (int k = 0; k < DEPTH; k++) m_b[k] <= san(mem[k]);
`ifdef HPDL_DUMP_CRLF_EN
      m_b[DEPTH]     <= 8'h0D;
      m_b[DEPTH + 1] <= 8'h0A;
`endif
    end
  end

  always @(negedge CLK) begin : cmp
    automatic logic etx = 1'b1;
    automatic logic eb = 1'b0;
    automatic logic ed = 1'b0;
    automatic logic er = 1'b0;
    automatic int   ea = 0;
    automatic int   off, d, bn;
    if (m_act && cyc > m_r) begin
      eb  = (cyc <= m_last);
      ed  = (cyc == m_last + 1);
      d   = cyc - (m_r + 1);
      if (d % SLOT == 0 && d / SLOT < DEPTH) begin
        er = 1'b1;
        ea = d / SLOT;
      end
      off = cyc - (m_r + 3);
      if (off >= 0 && off / SLOT < NF && off % SLOT < FR) begin
        bn = (off % SLOT) / BIT;
        if (bn == 0)      etx = 1'b0;
        else if (bn == 9) etx = 1'b1;
        else              etx = m_b[off / SLOT][bn - 1];
      end
    end
    chk("txd", TxD, etx);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("rd_en", rd_en, er);
    if (er) chk("rd_addr", rd_addr, ea);
    if (done) done_cnt <= done_cnt + 1;
  end

  // Independent receiver: samples each bit near its middle
  logic [7:0] dec_q[$];
  bit         d_on = 1'b0;
  int         d_cnt = 0;
  logic [7:0] d_sh = '0;

  always @(negedge CLK) begin
    if (RST) begin
      d_on <= 1'b0;
    end else if (!d_on) begin
      if (TxD === 1'b0) begin
        d_on  <= 1'b1;
        d_cnt <= 1;
      end
    end else begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == 9 * BIT + 52) begin
        dec_q.push_back(d_sh);
        d_on <= 1'b0;
      end else if (d_cnt % BIT == 52) begin
        d_sh <= {TxD, d_sh[7:1]};
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    tick(1);
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      tick(1);
      n++;
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  string hello = "HELLO WORLD 1234";

  task automatic load_hello();
    for (int k = 0; k < DEPTH; k++) mem[k] = hello[k];
  endtask

  initial begin
    int n, len;
    logic v;
    load_hello();
    tick(3);
    chk("reset_txd", TxD, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    dump_req = 1'b1;
    tick(1);
    dump_req = 1'b0;
    chk("req_during_reset", busy, 0);
    RST = 1'b0;
    tick(2);

    // Text dump with an ignored second request during frame 5
    dec_q.delete();
    done_cnt = 0;
    pulse_req();
    tick(2 + 4 * SLOT + 300);
    pulse_req();
    wait_done("hello_done");
    tick(5);
    chk("hello_count", dec_q.size(), NF);
    for (int k = 0; k < DEPTH && k < dec_q.size(); k++) chk("hello_byte", dec_q[k], hello[k]);
`ifdef HPDL_DUMP_CRLF_EN
    if (dec_q.size() == NF) begin
      chk("hello_cr", dec_q[DEPTH], 8'h0D);
      chk("hello_lf", dec_q[DEPTH + 1], 8'h0A);
    end
`endif
    chk("hello_done_once", done_cnt, 1);

    // Frame timing on 0x55, sanitising of out-of-range bytes
    mem[0] = 8'h55; mem[1] = 8'h61; mem[2] = 8'h1F; mem[3] = 8'h7F; mem[4] = 8'h5F;
    for (int k = 5; k < DEPTH; k++) mem[k] = 8'h41;
    dec_q.delete();
    pulse_req();
    chk("busy_after_req", busy, 1);
    chk("rd_en_after_req", rd_en, 1);
    n = 1;
    while (TxD !== 1'b0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("start_latency", n, 3);
    for (int j = 0; j < 10; j++) begin
      v = TxD;
      len = 0;
      while (TxD === v && len < 2000) begin
        tick(1);
        len++;
      end
      chk(j < 9 ? "bit_period" : "stop_plus_gap", len, j < 9 ? BIT : BIT + 3);
    end
    wait_done("san_done");
    tick(5);
    if (dec_q.size() >= 6) begin
      chk("san_0", dec_q[0], 8'h55);
      chk("san_1", dec_q[1], 8'h2E);
      chk("san_2", dec_q[2], 8'h2E);
      chk("san_3", dec_q[3], 8'h2E);
      chk("san_4", dec_q[4], 8'h5F);
      chk("san_5", dec_q[5], 8'h41);
    end else begin
      chk("san_count", dec_q.size(), NF);
    end

    // Reset during bit 3 of frame 2 abandons the dump
    load_hello();
    dec_q.delete();
    done_cnt = 0;
    pulse_req();
    tick(SLOT + 3 * BIT + 42);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("abort_txd", TxD, 1);
    chk("abort_busy", busy, 0);
    tick(3000);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_frames", dec_q.size(), 1);

    // Restart from address 0; entry 0 rewritten after it was fetched
    dec_q.delete();
    done_cnt = 0;
    pulse_req();
    tick(20);
    mem[0] = 8'h5A;
    wait_done("restart_done");
    tick(5);
    chk("restart_count", dec_q.size(), NF);
    if (dec_q.size() > 0) chk("old_entry0", dec_q[0], 8'h48);
    chk("restart_done_once", done_cnt, 1);

    // Next dump shows the new entry 0
    dec_q.delete();
    pulse_req();
    n = 0;
    while (dec_q.size() < 1 && n < 3000) begin
      tick(1);
      n++;
    end
    chk("new_entry0_seen", dec_q.size(), 1);
    if (dec_q.size() > 0) chk("new_entry0", dec_q[0], 8'h5A);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
